store_buffer_fwd: RTL

Parametrised in-order store buffer between the load/store unit and the data-memory arbiter. It generalises the existing store queue with configurable data width and depth, in-order commit release, speculative flush of unreleased entries, and byte-granular store-to-load forwarding. Committed (released) stores drain to memory in age order over a valid/ready handshake.

---
 rtl/store_buffer_fwd.sv | 130 +++++++++++++
 1 files changed

// File: rtl/store_buffer_fwd.sv
// In-order store buffer with commit release, speculative flush and drain to memory.
// Define STORE_BUFFER_FWD_EN to build byte-granular store-to-load forwarding.
module store_buffer_fwd #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 6,
    localparam int BYTES = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [ADDR_W-1:0]        push_addr,
    input  logic [BYTES-1:0]         push_be,
    input  logic [DATA_W-1:0]        push_data,
    input  logic [ID_W-1:0]          push_id,
    input  logic                     commit_valid,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [BYTES-1:0]         out_be,
    output logic [DATA_W-1:0]        out_data,
    output logic [ID_W-1:0]          out_id,
    input  logic [ADDR_W-1:0]        ld_addr,
    input  logic [BYTES-1:0]         ld_be,
    output logic                     ld_fwd_hit,
    output logic [DATA_W-1:0]        ld_fwd_data,
    output logic                     ld_conflict,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int IW  = $clog2(DEPTH);
    localparam int PW  = IW + 1;
    localparam int OFF = $clog2(BYTES);

    // Pointers carry a wrap bit: head (oldest), rel (next to release), tail (next free).
    logic [PW-1:0]     r_head, r_rel, r_tail;
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [BYTES-1:0]  r_be   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [ID_W-1:0]   r_id   [DEPTH];

    logic [PW-1:0]     w_count, w_rel_next, w_tail_next;
    logic              w_full, w_push, w_commit, w_pop;
    logic [IW-1:0]     w_idx;
    logic              w_found;
    logic              w_unused;

    assign w_count     = r_tail - r_head;
    assign w_full      = (w_count == PW'(DEPTH));
    assign push_ready  = ~w_full & ~flush;
    assign w_push      = push_valid & push_ready;
    assign w_commit    = commit_valid & (r_rel != r_tail);
    assign out_valid   = (r_head != r_rel);
    assign w_pop       = out_valid & out_ready;
    assign w_rel_next  = r_rel + PW'(w_commit);
    // Flush rewinds tail to the release point, keeping a same-cycle commit.
    assign w_tail_next = flush ? w_rel_next : r_tail + PW'(w_push);

    assign count    = w_count;
    assign empty    = (w_count == '0);
    assign out_addr = r_addr[r_head[IW-1:0]];
    assign out_be   = r_be[r_head[IW-1:0]];
    assign out_data = r_data[r_head[IW-1:0]];
    assign out_id   = r_id[r_head[IW-1:0]];
    assign w_unused = ^ld_addr[OFF-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_rel  <= '0;
            r_tail <= '0;
        end else begin
            r_head <= r_head + PW'(w_pop);
            r_rel  <= w_rel_next;
            r_tail <= w_tail_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail[IW-1:0]] <= push_addr;
            r_be[r_tail[IW-1:0]]   <= push_be;
            r_data[r_tail[IW-1:0]] <= push_data;
            r_id[r_tail[IW-1:0]]   <= push_id;
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    logic [BYTES-1:0]  w_sel_be;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_cover;
`endif

    // Walk valid entries oldest to youngest so the last match wins, independent of wrap.
    always_comb begin
        w_idx   = '0;
        w_found = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
        w_sel_be   = '0;
        w_sel_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head[IW-1:0] + IW'(i);
            if ((PW'(i) < w_count) &&
                (r_addr[w_idx][ADDR_W-1:OFF] == ld_addr[ADDR_W-1:OFF]) &&
                ((r_be[w_idx] & ld_be) != '0)) begin
                w_found = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
                w_sel_be   = r_be[w_idx];
                w_sel_data = r_data[w_idx];
`endif
            end
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    assign w_cover     = ((w_sel_be & ld_be) == ld_be);
    assign ld_fwd_hit  = w_found & w_cover;
    assign ld_fwd_data = ld_fwd_hit ? w_sel_data : '0;
    assign ld_conflict = w_found & ~w_cover;
`else
    assign ld_fwd_hit  = 1'b0;
    assign ld_fwd_data = '0;
    assign ld_conflict = w_found;
`endif

endmodule
